// File: rtl/iomem_gpio_disp_pkg.sv
// rtl/iomem_gpio_disp_pkg.sv - shared register map and CTRL layout for iomem_gpio_disp
package iomem_gpio_pkg;

  // Word offsets, i.e. iomem_addr[7:2]
  localparam logic [5:0] OFF_LED    = 6'h00;
  localparam logic [5:0] OFF_DIGIT0 = 6'h01;
  localparam logic [5:0] OFF_CTRL   = 6'h10;
  localparam logic [5:0] OFF_STATUS = 6'h11;
  localparam logic [5:0] OFF_INPUT  = 6'h12;

  localparam logic [8:0] CTRL_RESET      = 9'h1FF;
  localparam int         CTRL_BRIGHT_LSB = 0;
  localparam int         CTRL_EN_BIT     = 8;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int j = 0; j < 4; j++)
      if (strb[j]) r[j*8 +: 8] = new_v[j*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/iomem_gpio_disp_seg_scanner.sv
// rtl/iomem_gpio_disp_seg_scanner.sv - multiplexed seven-segment scanner with PWM brightness
module seg_scanner
  import iomem_gpio_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV_BITS = 15
) (
  input  logic                    clk_pll,
  input  logic                    resetn,
  input  logic [8*NUM_DIGITS-1:0] digits_i,
  input  logic [8:0]              ctrl_i,
  output logic [7:0]              seg_data_o,
  output logic [NUM_DIGITS-1:0]   seg_sel_n_o,
  output logic [3:0]              digit_o,
  output logic                    blank_o
);

  logic [SCAN_DIV_BITS-1:0] pre_q;
  logic [3:0]               digit_q;
  logic [7:0]               seg_data_q;
  logic [NUM_DIGITS-1:0]    sel_n_q;
  logic                     blank_q;
  logic [7:0]               duty;
  logic [7:0]               bright;
  logic                     lit;

  assign duty   = pre_q[SCAN_DIV_BITS-1 -: 8];
  assign bright = ctrl_i[CTRL_BRIGHT_LSB +: 8];
  // duty==0 is the anti-ghosting guard at the start of every digit slot
  assign lit    = ctrl_i[CTRL_EN_BIT] && (duty != 8'd0) && (duty < bright);

  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      pre_q      <= '0;
      digit_q    <= '0;
      seg_data_q <= '0;
      sel_n_q    <= '1;
      blank_q    <= 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
      if (&pre_q)
        digit_q <= (digit_q == 4'(NUM_DIGITS - 1)) ? 4'd0 : digit_q + 4'd1;
      blank_q    <= !lit;
      sel_n_q    <= lit ? ~(NUM_DIGITS'(1) << digit_q) : '1;
      seg_data_q <= lit ? digits_i[{digit_q, 3'b000} +: 8] : 8'h00;
    end
  end

  assign seg_data_o  = seg_data_q;
  assign seg_sel_n_o = sel_n_q;
  assign digit_o     = digit_q;
  assign blank_o     = blank_q;

endmodule

// File: rtl/iomem_gpio_disp.sv
// rtl/iomem_gpio_disp.sv - iomem slave: LED bank, segment display, CTRL/STATUS; GPIO_INPUT_EN adds gpio_in
module iomem_gpio_disp
  import iomem_gpio_pkg::*;
#(
  parameter logic [7:0] BASE_HI       = 8'h03,
  parameter int         LED_WIDTH     = 32,
  parameter int         NUM_DIGITS    = 4,
  parameter int         SCAN_DIV_BITS = 15
) (
  input  logic                  clk_pll,
  input  logic                  resetn,
  input  logic                  iomem_valid,
  output logic                  iomem_ready,
  input  logic [3:0]            iomem_wstrb,
  input  logic [31:0]           iomem_addr,
  input  logic [31:0]           iomem_wdata,
  output logic [31:0]           iomem_rdata,
  output logic [LED_WIDTH-1:0]  leds,
  output logic [7:0]            seg_data,
  output logic [NUM_DIGITS-1:0] seg_sel_n
`ifdef GPIO_INPUT_EN
  ,
  input  logic [31:0]           gpio_in
`endif
);

  logic                    ready_q;
  logic [31:0]             rdata_q;
  logic [LED_WIDTH-1:0]    leds_q, leds_d;
  logic [8:0]              ctrl_q, ctrl_d;
  logic [8*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [31:0]             rd, led_merge;
  logic [5:0]              off;
  logic                    hit, wr;
  logic [3:0]              digit_idx;
  logic                    blank;
  logic                    unused_addr_bits;

  assign off              = iomem_addr[7:2];
  assign hit              = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_HI);
  assign wr               = hit && (|iomem_wstrb);
  assign unused_addr_bits = ^{iomem_addr[23:8], iomem_addr[1:0]};

`ifdef GPIO_INPUT_EN
  logic [31:0] sync1_q, in_sync_q;
  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      sync1_q   <= '0;
      in_sync_q <= '0;
    end else begin
      sync1_q   <= gpio_in;
      in_sync_q <= sync1_q;
    end
  end
`endif

  // rd is taken from current register values, so a write acks with the old contents
  always_comb begin
    leds_d    = leds_q;
    ctrl_d    = ctrl_q;
    digits_d  = digits_q;
    rd        = '0;
    led_merge = byte_merge(32'(leds_q), iomem_wdata, iomem_wstrb);
    case (off)
      OFF_LED: begin
        rd = 32'(leds_q);
        if (wr) leds_d = led_merge[LED_WIDTH-1:0];
      end
      OFF_CTRL: begin
        rd = 32'(ctrl_q);
        if (wr && iomem_wstrb[0]) ctrl_d[7:0] = iomem_wdata[7:0];
        if (wr && iomem_wstrb[1]) ctrl_d[8]   = iomem_wdata[8];
      end
      OFF_STATUS: rd = {27'd0, blank, digit_idx};
`ifdef GPIO_INPUT_EN
      OFF_INPUT:  rd = in_sync_q;
`endif
      default: ;
    endcase
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (off == 6'(int'(OFF_DIGIT0) + d / 4)) begin
        rd[(d % 4)*8 +: 8] = digits_q[d*8 +: 8];
        if (wr && iomem_wstrb[d % 4]) digits_d[d*8 +: 8] = iomem_wdata[(d % 4)*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      leds_q   <= '0;
      ctrl_q   <= CTRL_RESET;
      digits_q <= '0;
    end else begin
      ready_q <= hit;
      if (hit) rdata_q <= rd;
      leds_q   <= leds_d;
      ctrl_q   <= ctrl_d;
      digits_q <= digits_d;
    end
  end

  seg_scanner #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SCAN_DIV_BITS(SCAN_DIV_BITS)
  ) u_scan (
    .clk_pll    (clk_pll),
    .resetn     (resetn),
    .digits_i   (digits_q),
    .ctrl_i     (ctrl_q),
    .seg_data_o (seg_data),
    .seg_sel_n_o(seg_sel_n),
    .digit_o    (digit_idx),
    .blank_o    (blank)
  );

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign leds        = leds_q;

endmodule
